// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between the
// display fetch engine (absolute priority, fixed latency) and the CPU bus
// (req/ack handshake, served on every cycle the display leaves free).
//
// Ports:
//   clk, reset                        video clock, async active-high reset
//   vid_rd, vid_addr                  display read strobe and address
//   vid_valid, vid_data               display read result, 2 edges after issue
//   cpu_req, cpu_we, cpu_addr,        CPU request, held until cpu_ack
//   cpu_wdata
//   cpu_ack, cpu_rdata, cpu_busy      CPU completion pulse, read data, busy flag
//   mem_addr, mem_we, mem_wdata       registered memory controls
//   mem_rdata                         memory read data (1-cycle latency)
//   cpu_wait_cnt, cpu_starved,        CPU wait counter and sticky starvation
//   starve_clr                        flag, built only with VRAM_ARB_STARVE_EN
module vram_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_rd,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [WAIT_W-1:0] cpu_wait_cnt,
    output logic              cpu_starved,
    input  logic              starve_clr
);
    typedef enum logic [1:0] {NONE, VID, CPU} tag_t;
    tag_t tag1, tag2;
    logic wr2;
    logic grant;
    // The display always wins; only one CPU access may be in flight.
    assign grant = !vid_rd && cpu_req && !cpu_busy;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag1      <= NONE;
            tag2      <= NONE;
            wr2       <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            cpu_busy  <= 1'b0;
        end else begin
            tag1   <= vid_rd ? VID : grant ? CPU : NONE;
            tag2   <= tag1;
            // mem_we of the stage-1 access tells stage 2 whether it was a write
            wr2    <= mem_we;
            mem_we <= grant && cpu_we;
            if (vid_rd || grant) mem_addr <= vid_rd ? vid_addr : cpu_addr;
            if (grant) mem_wdata <= cpu_wdata;
            vid_valid <= tag2 == VID;
            if (tag2 == VID) vid_data <= mem_rdata;
            cpu_ack <= tag2 == CPU;
            if (tag2 == CPU && !wr2) cpu_rdata <= mem_rdata;
            // grant is blocked while busy, so set and clear never coincide
            if (grant) cpu_busy <= 1'b1;
            else if (tag2 == CPU) cpu_busy <= 1'b0;
        end
    end
`ifdef VRAM_ARB_STARVE_EN
    logic [WAIT_W-1:0] wait_nxt;
    logic              starve_set;
    always_comb begin
        wait_nxt   = grant ? '0
                   : (cpu_req && !cpu_busy && !(&cpu_wait_cnt)) ? cpu_wait_cnt + 1'b1
                   : cpu_wait_cnt;
        // flag only on the transition into MAX_WAIT so a clear is not undone
        // while the counter sits at the threshold
        starve_set = wait_nxt == WAIT_W'(MAX_WAIT) && cpu_wait_cnt != WAIT_W'(MAX_WAIT);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_wait_cnt <= '0;
            cpu_starved  <= 1'b0;
        end else begin
            cpu_wait_cnt <= wait_nxt;
            cpu_starved  <= starve_set ? 1'b1 : starve_clr ? 1'b0 : cpu_starved;
        end
    end
`else
    logic unused_starve_clr;
    assign unused_starve_clr = starve_clr;
    assign cpu_wait_cnt      = '0;
    assign cpu_starved       = 1'b0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and random stimulus for vram_arbiter, checked each
// cycle against a transaction-level reference model (shadow memory, queue of
// pending display results with due edges, single outstanding CPU access).
module tb_vram_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int MW = 200;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_rd = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [WW-1:0] cpu_wait_cnt;
    logic          cpu_starved;
    logic          starve_clr = 1'b0;

    int compared = 0;
    int mismatched = 0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_W(WW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_wait_cnt(cpu_wait_cnt), .cpu_starved(cpu_starved), .starve_clr(starve_clr)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct { int due; logic [DW-1:0] d; } vres_t;
    vres_t         vq[$];
    logic [DW-1:0] ref_mem [2**AW];
    int            cyc = 0;
    int            cpu_due = -1;
    logic          m_busy = 1'b0;
    logic          cpu_rd = 1'b0;
    logic [DW-1:0] cpu_d = '0;
    logic          e_vvalid = 1'b0, e_ack = 1'b0, e_we = 1'b0;
    logic [DW-1:0] e_vdata = '0, e_rdata = '0, e_wdata = '0;
    logic [AW-1:0] e_addr = '0;
    int            e_wait = 0;
    logic          e_starved = 1'b0;
    int            vv_cnt = 0, we_cnt = 0, ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vid_valid"}, vid_valid, 0);
        chk({tag, "_vid_data"}, vid_data, 0);
        chk({tag, "_cpu_ack"}, cpu_ack, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_cpu_busy"}, cpu_busy, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_wait_cnt"}, cpu_wait_cnt, 0);
        chk({tag, "_starved"}, cpu_starved, 0);
    endtask

    // Check outputs of the last edge, then predict the outputs of the next
    // edge from the inputs that edge will sample.
    task automatic step();
        logic gr;
        logic busy0;
        int   old;
        if (reset) chk_zero("rst");
        else begin
            chk("vid_valid", vid_valid, e_vvalid);
            chk("vid_data", vid_data, e_vdata);
            chk("cpu_ack", cpu_ack, e_ack);
            chk("cpu_rdata", cpu_rdata, e_rdata);
            chk("cpu_busy", cpu_busy, m_busy);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("wait_cnt", cpu_wait_cnt, e_wait);
            chk("starved", cpu_starved, e_starved);
        end
        if (vid_valid) vv_cnt++;
        if (mem_we) we_cnt++;
        if (cpu_ack) ack_cnt++;
        cyc++;
        if (reset) begin
            vq.delete();
            cpu_due = -1; m_busy = 0; cpu_rd = 0;
            e_vvalid = 0; e_ack = 0; e_we = 0;
            e_vdata = 0; e_rdata = 0; e_wdata = 0; e_addr = 0;
            e_wait = 0; e_starved = 0;
        end else begin
            e_vvalid = 0; e_ack = 0; e_we = 0; gr = 0; busy0 = m_busy;
            if (vq.size() > 0 && vq[0].due == cyc) begin
                e_vvalid = 1; e_vdata = vq[0].d; void'(vq.pop_front());
            end
            if (vid_rd) begin
                vq.push_back('{cyc + 2, ref_mem[vid_addr]});
                e_addr = vid_addr;
            end else if (cpu_req && !m_busy) begin
                gr = 1; m_busy = 1; cpu_due = cyc + 2;
                e_addr = cpu_addr; e_wdata = cpu_wdata; e_we = cpu_we; cpu_rd = !cpu_we;
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else cpu_d = ref_mem[cpu_addr];
            end
            if (cpu_due == cyc) begin
                e_ack = 1; m_busy = 0;
                if (cpu_rd) e_rdata = cpu_d;
            end
`ifdef VRAM_ARB_STARVE_EN
            old = e_wait;
            if (gr) e_wait = 0;
            else if (cpu_req && !busy0 && e_wait < 2**WW - 1) e_wait++;
            if (e_wait == MW && old != MW) e_starved = 1;
            else if (starve_clr) e_starved = 0;
`else
            old = 0;
            if (gr && busy0 && old != 0) e_wait = 0;
`endif
        end
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        #2;
        if (cpu_ack) cpu_req = 0;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        while (cpu_req && n < 50) begin
            tick();
            n++;
        end
        chk("cpu_ack_timeout", cpu_req, 0);
        cpu_req = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        mem['h010] = 8'h41;
        mem['h123] = 8'hC3;
        mem['h155] = 8'h77;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = mem[i];

        tick();
        tick();
        reset = 0;
        tick();

        // single display read
        vid_rd = 1; vid_addr = 'h010;
        tick();
        vid_rd = 0;
        ack_cnt = 0;
        tick();
        tick();
        chk("single_valid", vid_valid, 1);
        chk("single_data", vid_data, 8'h41);
        tick();
        chk("single_pulse", vid_valid, 0);
        chk("single_no_ack", ack_cnt, 0);

        // display burst
        vv_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            vid_rd = 1; vid_addr = AW'('h010 + i);
            tick();
        end
        vid_rd = 0;
        repeat (4) tick();
        chk("burst_count", vv_cnt, 16);
        chk("burst_no_we", we_cnt, 0);

        // collision: CPU raised with a 4-cycle display burst
        cpu_req = 1; cpu_we = 0; cpu_addr = 'h123; n = 0;
        for (int i = 0; i < 4; i++) begin
            vid_rd = 1; vid_addr = AW'('h020 + i);
            tick();
            n++;
        end
        vid_rd = 0;
        while (cpu_req && n < 50) begin
            tick();
            n++;
        end
        chk("collide_latency", n, 7);
        chk("collide_data", cpu_rdata, 8'hC3);
        cpu_req = 0;

        // write then read back
        we_cnt = 0;
        cpu_access(1, 'h7FF, 8'h5A);
        chk("wr_we_pulses", we_cnt, 1);
        cpu_access(0, 'h7FF, 8'h00);
        chk("wr_rd_data", cpu_rdata, 8'h5A);
        chk("wr_rd_we", we_cnt, 1);

        // reset one cycle after a CPU grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 'h155;
        tick();
        chk("pre_rst_busy", cpu_busy, 1);
        tick();
        reset = 1; cpu_req = 0;
        #1;
        chk_zero("async_rst");
        tick();
        reset = 0;
        ack_cnt = 0;
        repeat (4) tick();
        chk("rst_no_ack", ack_cnt, 0);
        cpu_access(0, 'h155, 8'h00);
        chk("post_rst_data", cpu_rdata, 8'h77);

`ifdef VRAM_ARB_STARVE_EN
        cpu_req = 1; cpu_we = 0; cpu_addr = 'h010;
        for (int i = 1; i <= 250; i++) begin
            vid_rd = 1; vid_addr = AW'(i);
            tick();
            if (i == MW - 1) chk("starve_before", cpu_starved, 0);
            if (i == MW) begin
                chk("starve_set", cpu_starved, 1);
                chk("starve_cnt", cpu_wait_cnt, MW);
            end
        end
        chk("starve_cnt_250", cpu_wait_cnt, 250);
        vid_rd = 0;
        tick();
        chk("starve_cnt_grant", cpu_wait_cnt, 0);
        chk("starve_sticky", cpu_starved, 1);
        n = 0;
        while (cpu_req && n < 50) begin
            tick();
            n++;
        end
        cpu_req = 0;
        starve_clr = 1;
        tick();
        starve_clr = 0;
        chk("starve_clr", cpu_starved, 0);
`endif

        // random traffic with address overlap between display and CPU
        for (int i = 0; i < 3000; i++) begin
            vid_rd = ($urandom % 3) != 0;
            vid_addr = AW'($urandom % 64);
            if (!cpu_req && ($urandom % 4) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom);
                cpu_addr = AW'($urandom % 64); cpu_wdata = DW'($urandom);
            end else if (cpu_req && !cpu_busy && ($urandom % 16) == 0) cpu_req = 0;
            tick();
        end
        vid_rd = 0; cpu_req = 0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
